// File: rtl/ras_pkg.sv
// Shared constants for the return address stack and its controller.
package ras_pkg;

  localparam int unsigned XLEN              = 32;
  localparam int unsigned RAS_DEPTH_DEFAULT = 8;

  localparam logic [XLEN-1:0] RAS_EMPTY_PC   = 32'h0000_0000;
  localparam logic [XLEN-1:0] RAS_INVALID_PC = 32'hFFFF_FFFF;

endpackage

// File: rtl/ras_stack_if.sv
// Controller <-> return address stack interface.
// Optional RAS_STATS_EN adds the saturating overflow/underflow counters.
interface ras_stack_if
  import ras_pkg::*;
#(
  parameter int unsigned DEPTH = RAS_DEPTH_DEFAULT
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic            flush;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] pctoras;
  logic [XLEN-1:0] pcfromras;
  logic            empty;
  logic            full;
  logic [PTR_W:0]  count;
  logic            ovf;
  logic            unf;
`ifdef RAS_STATS_EN
  logic [15:0]     ovf_cnt;
  logic [15:0]     unf_cnt;

  modport master (
    output flush, push, pop, pctoras,
    input  pcfromras, empty, full, count, ovf, unf, ovf_cnt, unf_cnt
  );
  modport slave (
    input  flush, push, pop, pctoras,
    output pcfromras, empty, full, count, ovf, unf, ovf_cnt, unf_cnt
  );
`else
  modport master (
    output flush, push, pop, pctoras,
    input  pcfromras, empty, full, count, ovf, unf
  );
  modport slave (
    input  flush, push, pop, pctoras,
    output pcfromras, empty, full, count, ovf, unf
  );
`endif

endinterface

// File: rtl/ras_mem.sv
// Return address storage: one synchronous write port, one asynchronous read port.
module ras_mem
  import ras_pkg::*;
#(
  parameter int unsigned DEPTH = RAS_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [XLEN-1:0]          rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ras_stack.sv
// Circular LIFO of return addresses; oldest entry is overwritten on overflow.
// Optional RAS_STATS_EN adds saturating overflow/underflow event counters.
module ras_stack
  import ras_pkg::*;
#(
  parameter int unsigned DEPTH = RAS_DEPTH_DEFAULT
) (
  input  logic      clk,
  input  logic      reset_in,
  ras_stack_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] sp;
  logic [PTR_W-1:0] sp_inc;
  logic [PTR_W-1:0] waddr;
  logic [PTR_W:0]   cnt;
  logic             is_empty;
  logic             is_full;
  logic             replace;
  logic             we;
  logic             ovf_set;
  logic             unf_set;
  logic             ovf_q;
  logic             unf_q;
  logic [XLEN-1:0]  rdata;

  // Push+pop on a non-empty stack rewrites the top in place.
  always_comb begin
    is_empty = (cnt == '0);
    is_full  = (cnt == (PTR_W+1)'(DEPTH));
    sp_inc   = sp + PTR_W'(1);
    replace  = bus.push && bus.pop && !is_empty;
    we       = !reset_in && !bus.flush && bus.push;
    waddr    = replace ? sp : sp_inc;
    ovf_set  = bus.push && !bus.pop && is_full;
    unf_set  = bus.pop && is_empty;
  end

  always_ff @(posedge clk) begin
    if (reset_in || bus.flush) begin
      sp    <= PTR_W'(DEPTH - 1);
      cnt   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_set;
      unf_q <= unf_set;
      if (bus.push && !replace) begin
        sp <= sp_inc;
        if (!is_full) cnt <= cnt + (PTR_W+1)'(1);
      end else if (bus.pop && !bus.push && !is_empty) begin
        sp  <= sp - PTR_W'(1);
        cnt <= cnt - (PTR_W+1)'(1);
      end
    end
  end

  ras_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (bus.pctoras),
    .raddr (sp),
    .rdata (rdata)
  );

  assign bus.pcfromras = is_empty ? RAS_EMPTY_PC : rdata;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.count     = cnt;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;

`ifdef RAS_STATS_EN
  logic [15:0] ovf_cnt_q;
  logic [15:0] unf_cnt_q;

  // Event counters survive flush; only reset_in clears them.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else if (!bus.flush) begin
      if (ovf_set && ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
      if (unf_set && unf_cnt_q != 16'hFFFF) unf_cnt_q <= unf_cnt_q + 16'd1;
    end
  end

  assign bus.ovf_cnt = ovf_cnt_q;
  assign bus.unf_cnt = unf_cnt_q;
`endif

endmodule

// File: doc/ras_stack.md
# ras_stack

Return address stack storage that sits directly downstream of the RAS controller. It accepts push/pop strobes and a return address from the controller, keeps a fixed-depth circular LIFO of return addresses, and presents the current top-of-stack back to the controller as `pcfromras` with zero read latency. On overflow the oldest entry is silently overwritten. On underflow the stack holds its state and flags the event.

## Interface
- `DEPTH`, 8: number of entries; must be a power of two, ≥2.
- `PTR_W`, $clog2(DEPTH): pointer width (derived; do not override).
- `clk` input 1: single clock; all state updates on rising edge.
- `reset_in` input 1: synchronous, active-high reset.
- `flush` input 1: synchronous stack clear, driven from controller `reset_out`.
- `push` input 1: push strobe, sampled each cycle.
- `pop` input 1: pop strobe, sampled each cycle.
- `pctoras` input 32: return address written on push.
- `pcfromras` output 32: current top-of-stack; 32'h00000000 when empty.
- `empty` output 1: count == 0.
- `full` output 1: count == DEPTH.
- `count` output PTR_W+1: valid entries, 0..DEPTH.
- `ovf` output 1: registered one-cycle pulse, push while full.
- `unf` output 1: registered one-cycle pulse, pop while empty.

## Operation
- State: `sp` (PTR_W, index of top entry), `count`, storage array `mem[DEPTH]` of 32 bits. Storage is not reset. `pcfromras` is masked by `empty`.
- Priority per cycle: `reset_in` > `flush` > push/pop.
- Reset / flush: `sp`=DEPTH-1, `count`=0, `ovf`=`unf`=0. The first push therefore lands in `mem[0]`.
- Push only: `sp`←`sp`+1 mod DEPTH, `mem[sp+1]`←`pctoras`.
  - If not full: `count`+1.
  - If full: `count` stays DEPTH, the oldest entry is overwritten, and `ovf` pulses.
- Pop only:
  - If not empty: `sp`←`sp`-1 mod DEPTH, `count`-1.
  - If empty: no state change, and `unf` pulses.
- Push and pop together:
  - If not empty: replace top, i.e. `mem[sp]`←`pctoras`; `sp` and `count` unchanged; no flags.
  - If empty: behaves as push only, and `unf` also pulses.
- Neither: hold.
- `pctoras` value 32'hFFFFFFFF carries no special meaning here. It is stored if pushed.

## Timing
- `pcfromras`, `empty`, `full`, `count` are combinational from registered state. The pop target is valid in the same cycle the controller asserts `pop`.
- Push/pop effects are visible on outputs the cycle after the strobe edge.
- `ovf`/`unf` assert for exactly one cycle, the cycle after the offending edge.
- A pushed value is readable on `pcfromras` one cycle after the push. There is no write-to-read bypass within a cycle.
- Back-to-back strobes are supported every cycle with no bubbles.
- `reset_in` or `flush` asserted together with push/pop discards the push/pop. All outputs take reset values the next cycle: `pcfromras`=0, `empty`=1, `full`=0, `count`=0, `ovf`=`unf`=0.

## Configuration
- `RAS_STATS_EN` defined:
  - Adds outputs `ovf_cnt` [15:0] and `unf_cnt` [15:0].
  - These are saturating counters, incremented on each `ovf`/`unf` event, with saturation at 16'hFFFF.
  - They are cleared by `reset_in` only, not by `flush`.
- Not defined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package `ras_pkg`:
  - `XLEN`=32.
  - `RAS_DEPTH_DEFAULT`=8.
  - `RAS_EMPTY_PC`=32'h00000000.
  - `RAS_INVALID_PC`=32'hFFFFFFFF, shared with the controller.
- Sub-module `ras_mem`: DEPTH×XLEN array with one synchronous write port and one asynchronous read port. `ras_stack` owns pointers, count, flags and stats.

## Test plan
- Reset, push 0x100, 0x200, 0x300 → `pcfromras`=0x300, `count`=3. Then pop ×3 → 0x200, 0x100, then `empty`=1 with `pcfromras`=0.
- Push 9 values 0x10..0x90 with DEPTH=8 → `ovf` pulses once on the 9th, `count`=8. Pop ×8 → 0x90..0x20; 0x10 is lost.
- Pop on empty → `unf`=1 for one cycle, `count`=0, `sp` unchanged. A following push of 0x44 → `pcfromras`=0x44.
- Push 0xA0, 0xB0, then push+pop of 0xC0 → `count`=2, `pcfromras`=0xC0. Pop → 0xA0.
- Stack at `count`=5; assert `flush` together with `push` → next cycle `count`=0, `empty`=1, nothing stored. Repeat with `reset_in` → same result.
- `RAS_STATS_EN`: 3 overflows and 2 underflows → `ovf_cnt`=3, `unf_cnt`=2. `flush` keeps them; `reset_in` clears them to 0.
